fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of mainmem. It owns the program counter, drives the memory address in READ mode, and captures the combinational instruction word into a small in-order queue. Decode consumes the queue through a valid/ready handshake. It supports control-flow redirects and a sticky fault on illegal fetch targets.

Parameters:
STARTING_ADDR, 'h01000000, reset PC and base byte address of main memory
MEM_DEPTH_BYTES, 'h0100000, size of main memory in bytes (used by bounds check)
QUEUE_DEPTH, 2, instruction queue entries; power of 2, >= 2

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
mem_address  output  32  byte address to mainmem; equals current PC combinationally
mem_read_write  output  1  constant 0 (READ); fetch never writes
mem_data_out  input  32  instruction word from mainmem, little-endian assembled, valid same cycle as mem_address
redirect_valid  input  1  one-cycle pulse: load new PC and flush the queue
redirect_pc  input  32  redirect target byte address
inst_valid  output  1  queue head holds a valid instruction
inst_ready  input  1  decode accepts the head this cycle
inst_word  output  32  instruction at queue head
inst_pc  output  32  PC of instruction at queue head
fault  output  1  sticky fetch fault
fault_pc  output  32  address that caused the fault

Behaviour:
- Reset (async, immediate): pc=STARTING_ADDR; queue empty (count=0, pointers=0); inst_valid=0; inst_word=0; inst_pc=0; fault=0; fault_pc=0; state=BOOT.
- FSM states: BOOT, RUN, FAULT.
  - BOOT -> RUN unconditionally after 1 cycle. No fetch occurs in BOOT.
  - RUN -> FAULT on a fault condition.
  - FAULT is terminal until reset.
- push = (state==RUN) && (count < QUEUE_DEPTH) && !redirect_valid && no fault condition. count is sampled before any same-cycle pop, so a full queue never pushes, even when popping.
- On push: queue[wr] <= {pc, mem_data_out}; pc <= pc + 4 (mod 2^32, wraps silently).
- pop = inst_valid && inst_ready. Head advances. inst_word/inst_pc are driven from the queue head registers; no combinational path from mem_data_out.
- inst_valid = (count != 0) && (state != FAULT).
- Latency: with inst_ready=1, the first instruction appears on the cycle after the 2nd posedge following reset release. Sustained throughput is 1 instruction per cycle.
- Redirect in RUN or BOOT:
  - Has priority over push and pop.
  - Queue is flushed (count=0).
  - A pop presented in the same cycle is discarded.
  - pc <= redirect_pc; the next fetch occurs the following cycle. BOOT -> RUN still applies.
- Misaligned redirect (redirect_pc[1:0] != 0) is a fault condition:
  - state <= FAULT; fault <= 1; fault_pc <= redirect_pc.
  - The queue is flushed.
- In FAULT:
  - No push; redirect_valid is ignored.
  - mem_address holds the last pc.
  - fault and fault_pc are held.
- Redirect while the queue is empty or full: identical behaviour (flush, reload).
- mem_read_write = 0 at all times, including during reset.

Optional Feature:
FETCH_BOUNDS_CHECK_EN
- Defined: these are additional fault conditions:
  - a pc in RUN outside [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES-4], with fault_pc=pc and no push that cycle;
  - a redirect_pc outside the same range, with fault_pc=redirect_pc.
  - Misalignment is checked first and reports the same fault_pc.
- Undefined: no range check. Fault is raised only for a misaligned redirect, and any aligned address is fetched.

Test Plan:
- Reset, memory preloaded with words 0x00000093, 0x00100113, 0x00200193 at STARTING_ADDR, inst_ready=1 -> inst_pc 0x01000000, 0x01000004, 0x01000008 on consecutive cycles, with inst_word matching each word.
- inst_ready=0 for 5 cycles after the first valid -> queue holds 2 entries, mem_address stalls at 0x01000008, inst_word stable. Raise inst_ready -> in-order delivery with no loss or duplicate.
- redirect_valid with redirect_pc=0x01000100 while the queue is full and inst_ready=1 -> next delivered inst_pc=0x01000100, and the flushed entries never appear.
- redirect_pc=0x01000102 -> fault=1, fault_pc=0x01000102, inst_valid=0. A later redirect to 0x01000000 is ignored until reset.
- Assert reset mid-stream between clock edges -> all outputs reach reset values without a clock edge. After release, fetch restarts at 0x01000000.
- FETCH_BOUNDS_CHECK_EN defined, redirect_pc=0x01100000 -> fault=1, fault_pc=0x01100000. Undefined: same stimulus yields inst_valid with inst_pc=0x01100000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads mainmem, and queues {pc, word} pairs for decode.
// Optional FETCH_BOUNDS_CHECK_EN adds a memory-range fault on the PC and on redirect targets.
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000,
  parameter int unsigned QUEUE_DEPTH     = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]       state;
  logic [31:0]      pc;
  logic [31:0]      q_word [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        redir;
  logic        misaligned;
  logic        redir_oob;
  logic        pc_oob;
  logic        fault_hit;
  logic [31:0] fault_addr;
  logic        push;
  logic        pop;
  logic        flush;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= STARTING_ADDR) && (a <= LAST_ADDR);
  endfunction

  // Redirects are only honoured outside FAULT; misalignment takes precedence over range.
  always_comb begin
    redir      = redirect_valid && (state != ST_FAULT);
    misaligned = redir && (redirect_pc[1:0] != 2'b00);
    redir_oob  = BOUNDS_EN && redir && !in_range(redirect_pc);
    pc_oob     = BOUNDS_EN && (state == ST_RUN) && !redirect_valid && !in_range(pc);
    fault_hit  = misaligned || redir_oob || pc_oob;
    fault_addr = (misaligned || redir_oob) ? redirect_pc : pc;
    push       = (state == ST_RUN) && (count < FULL_COUNT) && !redirect_valid && !fault_hit;
    pop        = inst_valid && inst_ready;
    flush      = redir || fault_hit;
  end

  assign mem_address    = pc;
  assign mem_read_write = 1'b0;
  assign inst_valid     = (count != '0) && (state != ST_FAULT);
  assign inst_word      = q_word[rd_ptr];
  assign inst_pc        = q_pc[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= STARTING_ADDR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fault    <= 1'b0;
      fault_pc <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        q_word[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      if (fault_hit) begin
        state    <= ST_FAULT;
        fault    <= 1'b1;
        fault_pc <= fault_addr;
      end else if (state == ST_BOOT) begin
        state <= ST_RUN;
      end

      // Flush discards any same-cycle pop; a faulting redirect leaves pc untouched.
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        if (!fault_hit) pc <= redirect_pc;
      end else begin
        if (push) begin
          q_word[wr_ptr] <= mem_data_out;
          q_pc[wr_ptr]   <= pc;
          wr_ptr         <= wr_ptr + 1'b1;
          pc             <= pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational mainmem model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .STARTING_ADDR   (32'h0100_0000),
    .MEM_DEPTH_BYTES (32'h0010_0000),
    .QUEUE_DEPTH     (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clock = ~clock;

  // Three preloaded words at the base; everywhere else returns address ^ 0xDEAD0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0100_0000: return 32'h0000_0093;
      32'h0100_0004: return 32'h0010_0113;
      32'h0100_0008: return 32'h0020_0193;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  always_comb mem_data_out = mem_word(mem_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b1;
    @(negedge clock);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_word", inst_word, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_addr", mem_address, 32'h0100_0000);
    chk("rst_rw", 32'(mem_read_write), 32'd0);

    reset = 1'b0;
    step();
    chk("boot_valid", 32'(inst_valid), 32'd0);
    chk("boot_addr", mem_address, 32'h0100_0000);
    step();
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_pc", inst_pc, 32'h0100_0000);
    chk("first_word", inst_word, 32'h0000_0093);
    chk("first_addr", mem_address, 32'h0100_0004);
    step();
    chk("second_pc", inst_pc, 32'h0100_0004);
    chk("second_word", inst_word, 32'h0010_0113);
    step();
    chk("third_pc", inst_pc, 32'h0100_0008);
    chk("third_word", inst_word, 32'h0020_0193);
    chk("third_addr", mem_address, 32'h0100_000C);

    // Asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(inst_valid), 32'd0);
    chk("async_word", inst_word, 32'h0);
    chk("async_pc", inst_pc, 32'h0);
    chk("async_addr", mem_address, 32'h0100_0000);
    chk("async_fault", 32'(fault), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    inst_ready = 1'b0;

    step();
    step();
    chk("restart_valid", 32'(inst_valid), 32'd1);
    chk("restart_pc", inst_pc, 32'h0100_0000);
    repeat (4) step();
    chk("stall_addr", mem_address, 32'h0100_0008);
    chk("stall_pc", inst_pc, 32'h0100_0000);
    chk("stall_word", inst_word, 32'h0000_0093);

    inst_ready = 1'b1;
    step();
    chk("drain1_pc", inst_pc, 32'h0100_0004);
    chk("drain1_word", inst_word, 32'h0010_0113);
    step();
    chk("drain2_pc", inst_pc, 32'h0100_0008);
    chk("drain2_word", inst_word, 32'h0020_0193);
    step();
    chk("drain3_pc", inst_pc, 32'h0100_000C);
    chk("drain3_word", inst_word, 32'hDFAD_000C);

    inst_ready = 1'b0;
    step();
    step();
    chk("full_addr", mem_address, 32'h0100_0014);
    chk("full_pc", inst_pc, 32'h0100_000C);

    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0100;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", mem_address, 32'h0100_0100);
    step();
    chk("redir_valid", 32'(inst_valid), 32'd1);
    chk("redir_pc", inst_pc, 32'h0100_0100);
    chk("redir_word", inst_word, 32'hDFAD_0100);
    step();
    chk("redir2_pc", inst_pc, 32'h0100_0104);
    chk("redir2_word", inst_word, 32'hDFAD_0104);

    redirect_valid = 1'b1;
    redirect_pc = 32'h0110_0000;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("oob_fault", 32'(fault), 32'd1);
    chk("oob_fault_pc", fault_pc, 32'h0110_0000);
    chk("oob_valid", 32'(inst_valid), 32'd0);
`else
    chk("oob_nofault", 32'(fault), 32'd0);
    chk("oob_flush", 32'(inst_valid), 32'd0);
    step();
    chk("oob_valid", 32'(inst_valid), 32'd1);
    chk("oob_pc", inst_pc, 32'h0110_0000);
    chk("oob_word", inst_word, 32'hDFBD_0000);
`endif

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0102;
    step();
    redirect_valid = 1'b0;
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h0100_0102);
    chk("mis_valid", 32'(inst_valid), 32'd0);
    chk("mis_addr", mem_address, 32'h0100_0004);

    redirect_valid = 1'b1;
    redirect_pc = 32'h0100_0000;
    step();
    redirect_valid = 1'b0;
    step();
    chk("sticky_fault", 32'(fault), 32'd1);
    chk("sticky_fault_pc", fault_pc, 32'h0100_0102);
    chk("sticky_valid", 32'(inst_valid), 32'd0);
    chk("sticky_addr", mem_address, 32'h0100_0004);

    reset = 1'b1;
    #1;
    chk("clear_fault", 32'(fault), 32'd0);
    chk("clear_addr", mem_address, 32'h0100_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
